// File: rtl/sonic_tx_arbiter.sv
// ============================================================================
// Module   : sonic_tx_arbiter
// Brief    : Round-robin TX/MSI arbiter and TLP mux in front of the PCIe core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonic_tx_arb_fsm #(
  parameter  int NUM_CLIENTS   = 3,
  parameter  int GRANT_TIMEOUT = 64,
  localparam int IW            = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_init,
  input  logic [NUM_CLIENTS-1:0] i_ready,
  input  logic [NUM_CLIENTS-1:0] i_busy,
  output logic                   o_active,
  output logic [IW-1:0]          o_owner,
  output logic [NUM_CLIENTS-1:0] o_sel
);

  localparam int CW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(GRANT_TIMEOUT - 1);
  localparam logic [IW-1:0] c_LAST_RST = IW'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_OWNED = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   w_pick;
  logic            w_any;
  int              w_idx;

  // Rotating scan starting just after the last owner.
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    w_idx  = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= NUM_CLIENTS) w_idx = w_idx - NUM_CLIENTS;
      if (!w_any && i_ready[w_idx[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (i_busy[r_owner]) begin
          w_state_nxt = S_OWNED;
        end else if (!i_ready[r_owner] || (r_cnt == c_CNT_LAST)) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_OWNED: begin
        if (!i_busy[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= c_LAST_RST;
      r_cnt   <= '0;
    end else if (i_init) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= c_LAST_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_active = (r_state != S_IDLE);
  assign o_owner  = r_owner;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_sel
    assign o_sel[i] = o_active && (r_owner == IW'(i));
  end

endmodule

module sonic_tx_arbiter #(
  parameter  int NUM_CLIENTS   = 3,
  parameter  int GRANT_TIMEOUT = 64,
  localparam int IW            = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_CLIENTS-1:0]     c_tx_req,
  input  logic [NUM_CLIENTS*128-1:0] c_tx_desc,
  input  logic [NUM_CLIENTS-1:0]     c_tx_dv,
  input  logic [NUM_CLIENTS-1:0]     c_tx_dfr,
  input  logic [NUM_CLIENTS-1:0]     c_tx_err,
  input  logic [NUM_CLIENTS*128-1:0] c_tx_data,
  input  logic [NUM_CLIENTS-1:0]     c_tx_ready,
  input  logic [NUM_CLIENTS-1:0]     c_tx_busy,
  output logic [NUM_CLIENTS-1:0]     c_tx_sel,
  output logic [NUM_CLIENTS-1:0]     c_tx_ack,
  output logic                       c_tx_ws,
  output logic [NUM_CLIENTS-1:0]     c_tx_ready_others,
  input  logic [NUM_CLIENTS-1:0]     c_msi_req,
  input  logic [NUM_CLIENTS-1:0]     c_msi_ready,
  input  logic [NUM_CLIENTS-1:0]     c_msi_busy,
  output logic [NUM_CLIENTS-1:0]     c_msi_sel,
  output logic [NUM_CLIENTS-1:0]     c_msi_ack,
  output logic                       tx_req,
  output logic [127:0]               tx_desc,
  output logic                       tx_dv,
  output logic                       tx_dfr,
  output logic [127:0]               tx_data,
  output logic                       tx_err,
  input  logic                       tx_ack,
  input  logic                       tx_ws,
  output logic                       app_msi_req,
  input  logic                       app_msi_ack
);

  logic                   w_tx_active, w_msi_active;
  logic [IW-1:0]          w_tx_owner, w_msi_owner;
  logic [NUM_CLIENTS-1:0] w_tx_sel, w_msi_sel;

  sonic_tx_arb_fsm #(
    .NUM_CLIENTS  (NUM_CLIENTS),
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) u_tx_fsm (
    .clk     (clk_in),
    .rst     (reset),
    .i_init  (init),
    .i_ready (c_tx_ready),
    .i_busy  (c_tx_busy),
    .o_active(w_tx_active),
    .o_owner (w_tx_owner),
    .o_sel   (w_tx_sel)
  );

  sonic_tx_arb_fsm #(
    .NUM_CLIENTS  (NUM_CLIENTS),
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) u_msi_fsm (
    .clk     (clk_in),
    .rst     (reset),
    .i_init  (init),
    .i_ready (c_msi_ready),
    .i_busy  (c_msi_busy),
    .o_active(w_msi_active),
    .o_owner (w_msi_owner),
    .o_sel   (w_msi_sel)
  );

  assign c_tx_sel  = w_tx_sel;
  assign c_msi_sel = w_msi_sel;
  // Sel already encodes (active && owner==i), so it doubles as the ack route mask.
  assign c_tx_ack  = w_tx_sel & {NUM_CLIENTS{tx_ack}};
  assign c_msi_ack = w_msi_sel & {NUM_CLIENTS{app_msi_ack}};
  assign c_tx_ws   = tx_ws;

  assign tx_req      = w_tx_active & c_tx_req[w_tx_owner];
  assign tx_dv       = w_tx_active & c_tx_dv[w_tx_owner];
  assign tx_dfr      = w_tx_active & c_tx_dfr[w_tx_owner];
  assign tx_err      = w_tx_active & c_tx_err[w_tx_owner];
  assign tx_desc     = w_tx_active ? c_tx_desc[w_tx_owner*128 +: 128] : '0;
  assign tx_data     = w_tx_active ? c_tx_data[w_tx_owner*128 +: 128] : '0;
  assign app_msi_req = w_msi_active & c_msi_req[w_msi_owner];

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_others
    localparam logic [NUM_CLIENTS-1:0] c_SELF = NUM_CLIENTS'(1) << i;
    assign c_tx_ready_others[i] = |(c_tx_busy & ~c_SELF);
  end

endmodule

`default_nettype wire

// File: tb/tb_sonic_tx_arbiter.sv
// ============================================================================
// Module   : tb_sonic_tx_arbiter
// Brief    : Self-checking bench for sonic_tx_arbiter with a grant-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sonic_tx_arbiter;

  localparam int N = 3;

  logic           clk_in = 1'b0;
  logic           reset  = 1'b1;
  logic           init   = 1'b0;
  logic [N-1:0]   c_tx_req, c_tx_dv, c_tx_dfr, c_tx_err, c_tx_ready, c_tx_busy;
  logic [N-1:0]   c_msi_req, c_msi_ready, c_msi_busy;
  logic [N*128-1:0] c_tx_desc, c_tx_data;
  logic           tx_ack, tx_ws, app_msi_ack;
  logic [N-1:0]   c_tx_sel, c_tx_ack, c_tx_ready_others, c_msi_sel, c_msi_ack;
  logic           c_tx_ws, tx_req, tx_dv, tx_dfr, tx_err, app_msi_req;
  logic [127:0]   tx_desc, tx_data;

  int n_vec = 0;
  int n_err = 0;
  int q_owner[$];

  sonic_tx_arbiter #(.NUM_CLIENTS(N), .GRANT_TIMEOUT(64)) dut (
    .clk_in(clk_in), .reset(reset), .init(init),
    .c_tx_req(c_tx_req), .c_tx_desc(c_tx_desc), .c_tx_dv(c_tx_dv),
    .c_tx_dfr(c_tx_dfr), .c_tx_err(c_tx_err), .c_tx_data(c_tx_data),
    .c_tx_ready(c_tx_ready), .c_tx_busy(c_tx_busy), .c_tx_sel(c_tx_sel),
    .c_tx_ack(c_tx_ack), .c_tx_ws(c_tx_ws), .c_tx_ready_others(c_tx_ready_others),
    .c_msi_req(c_msi_req), .c_msi_ready(c_msi_ready), .c_msi_busy(c_msi_busy),
    .c_msi_sel(c_msi_sel), .c_msi_ack(c_msi_ack),
    .tx_req(tx_req), .tx_desc(tx_desc), .tx_dv(tx_dv), .tx_dfr(tx_dfr),
    .tx_data(tx_data), .tx_err(tx_err), .tx_ack(tx_ack), .tx_ws(tx_ws),
    .app_msi_req(app_msi_req), .app_msi_ack(app_msi_ack)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs;
    c_tx_req = '0; c_tx_dv = '0; c_tx_dfr = '0; c_tx_err = '0;
    c_tx_ready = '0; c_tx_busy = '0; c_tx_desc = '0; c_tx_data = '0;
    c_msi_req = '0; c_msi_ready = '0; c_msi_busy = '0;
    tx_ack = 1'b0; tx_ws = 1'b0; app_msi_ack = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_vec++; if (c_tx_sel !== 3'b000) begin n_err++; $display("FAIL reset_tx_sel: got %b expected 000", c_tx_sel); end
    n_vec++; if (c_msi_sel !== 3'b000) begin n_err++; $display("FAIL reset_msi_sel: got %b expected 000", c_msi_sel); end
    n_vec++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
    n_vec++; if (tx_desc !== '0) begin n_err++; $display("FAIL reset_tx_desc: got %h expected 0", tx_desc); end
    n_vec++; if (app_msi_req !== 1'b0) begin n_err++; $display("FAIL reset_msi_req: got %b expected 0", app_msi_req); end
    @(negedge clk_in);
    reset = 1'b0;
    tick;
    n_vec++; if (c_tx_sel !== 3'b000) begin n_err++; $display("FAIL idle_no_ready: got %b expected 000", c_tx_sel); end
  endtask

  task automatic test_basic;
    int exp;
    c_tx_ready = 3'b001;
    q_owner.push_back(0);
    tick;
    exp = q_owner.pop_front();
    n_vec++; if (c_tx_sel !== 3'(1 << exp)) begin n_err++; $display("FAIL basic_grant: got %b expected %b", c_tx_sel, 3'(1 << exp)); end
    c_tx_busy = 3'b001; c_tx_req = 3'b001;
    c_tx_desc[127:0]   = {16{8'hA5}};
    c_tx_desc[255:128] = {16{8'h3C}};
    tick;
    n_vec++; if (c_tx_sel !== 3'b001) begin n_err++; $display("FAIL basic_owned_sel: got %b expected 001", c_tx_sel); end
    n_vec++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL basic_tx_req: got %b expected 1", tx_req); end
    n_vec++; if (tx_desc !== {16{8'hA5}}) begin n_err++; $display("FAIL basic_tx_desc: got %h expected %h", tx_desc, {16{8'hA5}}); end
    tx_ack = 1'b1; #1;
    n_vec++; if (c_tx_ack !== 3'b001) begin n_err++; $display("FAIL basic_tx_ack: got %b expected 001", c_tx_ack); end
    clear_inputs;
    tick;
    n_vec++; if (c_tx_sel !== 3'b000) begin n_err++; $display("FAIL basic_release: got %b expected 000", c_tx_sel); end
    n_vec++; if (tx_desc !== '0) begin n_err++; $display("FAIL basic_idle_desc: got %h expected 0", tx_desc); end
  endtask

  task automatic test_back_to_back;
    int grants = 0, idle = 0, bcnt = 0, exp;
    logic [N-1:0] prev;
    init = 1'b1; tick; init = 1'b0;
    q_owner.push_back(0); q_owner.push_back(1); q_owner.push_back(2); q_owner.push_back(0);
    c_tx_ready = 3'b111;
    prev = 3'b000;
    for (int k = 0; k < 80 && grants < 4; k++) begin
      tick;
      if (c_tx_sel !== 3'b000 && prev === 3'b000) begin
        exp = q_owner.pop_front();
        n_vec++; if (c_tx_sel !== 3'(1 << exp)) begin n_err++; $display("FAIL rr_order: got %b expected %b", c_tx_sel, 3'(1 << exp)); end
        if (grants > 0) begin
          n_vec++; if (idle != 1) begin n_err++; $display("FAIL rr_idle_gap: got %0d expected 1", idle); end
        end
        grants++; idle = 0; bcnt = 0;
        c_tx_busy = c_tx_sel;
      end else if (c_tx_sel === 3'b000) begin
        idle++;
      end else begin
        bcnt++;
        if (bcnt == 4) c_tx_busy = 3'b000;
      end
      prev = c_tx_sel;
    end
    n_vec++; if (grants != 4) begin n_err++; $display("FAIL rr_grant_count: got %0d expected 4", grants); end
    clear_inputs;
    tick; tick;
  endtask

  task automatic test_timeout;
    int cnt = 1, exp;
    c_tx_ready = 3'b010;
    q_owner.push_back(1);
    tick;
    exp = q_owner.pop_front();
    n_vec++; if (c_tx_sel !== 3'(1 << exp)) begin n_err++; $display("FAIL to_grant: got %b expected %b", c_tx_sel, 3'(1 << exp)); end
    c_tx_ready = 3'b110;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (c_tx_sel !== 3'b010) break;
      cnt++;
    end
    n_vec++; if (cnt != 64) begin n_err++; $display("FAIL to_hold_cycles: got %0d expected 64", cnt); end
    n_vec++; if (c_tx_sel !== 3'b000) begin n_err++; $display("FAIL to_revoked: got %b expected 000", c_tx_sel); end
    q_owner.push_back(2);
    tick;
    exp = q_owner.pop_front();
    n_vec++; if (c_tx_sel !== 3'(1 << exp)) begin n_err++; $display("FAIL to_next_grant: got %b expected %b", c_tx_sel, 3'(1 << exp)); end
    clear_inputs;
    tick; tick;
  endtask

  task automatic test_msi_concurrent;
    int exp;
    c_tx_ready = 3'b100; c_msi_ready = 3'b001;
    q_owner.push_back(2);
    tick;
    exp = q_owner.pop_front();
    n_vec++; if (c_tx_sel !== 3'(1 << exp)) begin n_err++; $display("FAIL msi_tx_grant: got %b expected %b", c_tx_sel, 3'(1 << exp)); end
    n_vec++; if (c_msi_sel !== 3'b001) begin n_err++; $display("FAIL msi_grant: got %b expected 001", c_msi_sel); end
    c_tx_busy = 3'b100; c_msi_busy = 3'b001; c_msi_req = 3'b001; c_tx_req = 3'b100;
    c_tx_desc[127:0]   = {16{8'hFF}};
    c_tx_desc[383:256] = {4{32'hDEADBEEF}};
    c_tx_data[383:256] = {4{32'h01234567}};
    tick;
    n_vec++; if (app_msi_req !== 1'b1) begin n_err++; $display("FAIL msi_req_hi: got %b expected 1", app_msi_req); end
    n_vec++; if (tx_desc !== {4{32'hDEADBEEF}}) begin n_err++; $display("FAIL msi_tx_desc: got %h expected %h", tx_desc, {4{32'hDEADBEEF}}); end
    n_vec++; if (tx_data !== {4{32'h01234567}}) begin n_err++; $display("FAIL msi_tx_data: got %h expected %h", tx_data, {4{32'h01234567}}); end
    n_vec++; if (c_tx_ready_others !== 3'b011) begin n_err++; $display("FAIL ready_others: got %b expected 011", c_tx_ready_others); end
    c_msi_req = 3'b000; #1;
    n_vec++; if (app_msi_req !== 1'b0) begin n_err++; $display("FAIL msi_req_lo: got %b expected 0", app_msi_req); end
    app_msi_ack = 1'b1; #1;
    n_vec++; if (c_msi_ack !== 3'b001) begin n_err++; $display("FAIL msi_ack: got %b expected 001", c_msi_ack); end
    n_vec++; if (c_tx_ack !== 3'b000) begin n_err++; $display("FAIL msi_no_tx_ack: got %b expected 000", c_tx_ack); end
    app_msi_ack = 1'b0; tx_ack = 1'b1; #1;
    n_vec++; if (c_tx_ack !== 3'b100) begin n_err++; $display("FAIL tx_ack_owner2: got %b expected 100", c_tx_ack); end
    n_vec++; if (c_msi_ack !== 3'b000) begin n_err++; $display("FAIL tx_no_msi_ack: got %b expected 000", c_msi_ack); end
    clear_inputs;
    tick; tick;
  endtask

  task automatic test_ws_and_init;
    int exp;
    c_tx_ready = 3'b001;
    q_owner.push_back(0);
    tick;
    exp = q_owner.pop_front();
    n_vec++; if (c_tx_sel !== 3'(1 << exp)) begin n_err++; $display("FAIL ws_grant: got %b expected %b", c_tx_sel, 3'(1 << exp)); end
    c_tx_busy = 3'b001;
    tick;
    tx_ws = 1'b1; c_tx_ready = 3'b000; #1;
    n_vec++; if (c_tx_ws !== 1'b1) begin n_err++; $display("FAIL ws_hi: got %b expected 1", c_tx_ws); end
    tick; tick; tick;
    n_vec++; if (c_tx_sel !== 3'b001) begin n_err++; $display("FAIL ws_hold: got %b expected 001", c_tx_sel); end
    tx_ws = 1'b0; c_tx_dv = 3'b001; #1;
    n_vec++; if (c_tx_ws !== 1'b0) begin n_err++; $display("FAIL ws_lo: got %b expected 0", c_tx_ws); end
    n_vec++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL init_dv_before: got %b expected 1", tx_dv); end
    init = 1'b1;
    tick;
    init = 1'b0;
    n_vec++; if (c_tx_sel !== 3'b000) begin n_err++; $display("FAIL init_sel: got %b expected 000", c_tx_sel); end
    n_vec++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL init_dv: got %b expected 0", tx_dv); end
    clear_inputs;
    tick;
  endtask

  task automatic test_async_reset;
    c_tx_ready = 3'b001;
    tick;
    c_tx_busy = 3'b001; c_tx_dv = 3'b001;
    tick;
    n_vec++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL arst_dv_before: got %b expected 1", tx_dv); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (c_tx_sel !== 3'b000) begin n_err++; $display("FAIL arst_sel: got %b expected 000", c_tx_sel); end
    n_vec++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL arst_dv: got %b expected 0", tx_dv); end
    clear_inputs;
    #1 reset = 1'b0;
    tick;
  endtask

  initial begin
    clear_inputs;
    test_reset;
    test_basic;
    test_back_to_back;
    test_timeout;
    test_msi_concurrent;
    test_ws_and_init;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sonic_tx_arbiter.md
Name: sonic_tx_arbiter

Overview:
- Shared arbiter and mux in front of the PCIe backend transmit port and the core MSI request port.
- Clients are the chaining DMA engines, the command/RC-update engine and the IRQ generator. Each drives its own tx_req/tx_desc/tx_dv/tx_dfr/tx_data/tx_err plus tx_ready/tx_busy and msi_ready/msi_busy.
- Issues one-hot tx_sel/msi_sel grants using round-robin, forwards the owner's TLP signals to the core, and routes tx_ack/app_msi_ack back to the owner only.

Parameters:
- NUM_CLIENTS, 3, number of transmit clients; client index 0..NUM_CLIENTS-1.
- GRANT_TIMEOUT, 64, cycles a granted client may hold tx_sel/msi_sel without asserting busy before the grant is revoked.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  software reset; synchronous clear of all arbitration state.
- c_tx_req  in  NUM_CLIENTS  per-client tx_req.
- c_tx_desc  in  NUM_CLIENTS*128  client i at [i*128 +: 128].
- c_tx_dv, c_tx_dfr, c_tx_err  in  NUM_CLIENTS each  per-client data strobes.
- c_tx_data  in  NUM_CLIENTS*128  client i at [i*128 +: 128].
- c_tx_ready  in  NUM_CLIENTS  client requests the tx bus.
- c_tx_busy  in  NUM_CLIENTS  client is mid-transaction.
- c_tx_sel  out  NUM_CLIENTS  one-hot tx grant.
- c_tx_ack  out  NUM_CLIENTS  core tx_ack routed to the owner.
- c_tx_ws  out  1  core tx_ws broadcast to all clients.
- c_tx_ready_others  out  NUM_CLIENTS  bit i = OR of c_tx_busy[j] for j≠i.
- c_msi_req, c_msi_ready, c_msi_busy  in  NUM_CLIENTS each  per-client MSI signals.
- c_msi_sel, c_msi_ack  out  NUM_CLIENTS each  MSI grant and routed app_msi_ack.
- tx_req, tx_dv, tx_dfr, tx_err  out  1 each  to core.
- tx_desc, tx_data  out  128 each  to core.
- tx_ack, tx_ws  in  1 each  from core.
- app_msi_req  out  1  to core.
- app_msi_ack  in  1  from core.

Behaviour:
- Two independent arbiters, TX and MSI, with identical FSMs. Each FSM has states IDLE, GRANT and OWNED, a registered owner index, a last-owner pointer and a timeout counter.
- TX FSM uses c_tx_ready/c_tx_busy; MSI FSM uses c_msi_ready/c_msi_busy.
- IDLE:
  - Sel outputs are all 0.
  - If any ready bit is set, pick the first set bit scanning upward from last+1 (mod NUM_CLIENTS), register it as owner, go to GRANT. The sel bit asserts the next cycle.
- GRANT:
  - sel[owner]=1.
  - busy[owner]=1 → OWNED.
  - Else ready[owner]=0, or the timeout counter reaches GRANT_TIMEOUT-1 → IDLE, last<=owner.
  - The counter runs only in GRANT and clears on entry.
- OWNED:
  - sel[owner] stays 1.
  - busy[owner] falls → IDLE, last<=owner. There is no timeout in OWNED.
- Each release costs exactly one IDLE cycle, so there is never back-to-back grant overlap.
- Ready bits from non-owners are ignored while in GRANT or OWNED.
- Mux is combinational from the registered owner:
  - In GRANT/OWNED, tx_req/tx_desc/tx_dv/tx_dfr/tx_data/tx_err come from the owner's slices.
  - In IDLE, tx_req/tx_dv/tx_dfr/tx_err = 0 and tx_desc/tx_data = 0.
- c_tx_ack[i] = tx_ack & (TX FSM ≠ IDLE) & (owner==i). c_tx_ws = tx_ws.
- app_msi_req = c_msi_req[msi_owner] when the MSI FSM ≠ IDLE, else 0. c_msi_ack[i] follows the same rule as c_tx_ack.
- c_tx_ready_others is combinational from c_tx_busy, independent of the FSM.
- Reset values (async reset, or init sampled high at a clock edge):
  - Both FSMs in IDLE, owners 0, last = NUM_CLIENTS-1 (so client 0 wins first), counters 0.
  - All sel/ack/req/dv/dfr/err outputs are 0; tx_desc/tx_data are 0.
- init asserted mid-transaction drops the grant immediately next cycle. Clients are required to abandon on init as well.
- Simultaneous ready from all clients is served strictly in rotation. A client re-raising ready right after release waits behind any other pending clients.
- No combinational path exists from c_tx_ready to c_tx_sel.

Test Plan:
- After reset, c_tx_ready=3'b001 → c_tx_sel=001 one cycle later. Client 0 raises busy and drives tx_req with tx_desc=128'hA5… → tx_req/tx_desc on the core side match. Core tx_ack=1 → c_tx_ack=001.
- c_tx_ready=3'b111 held; each client does busy for 4 cycles then drops → grant order 0,1,2,0 with exactly one idle (sel=000) cycle between grants.
- Client 1 granted but never raises busy → c_tx_sel=010 for exactly 64 cycles, then 000. The next grant goes to client 2 if it is ready.
- Client 2 owns TX and is busy while client 0 owns MSI: app_msi_req follows c_msi_req[0]; app_msi_ack=1 → c_msi_ack=001 only; TX path is unaffected. c_tx_ready_others=3'b011 while only client 2 is busy.
- Client 0 is OWNED with tx_dv=1 and init pulses 1 cycle → next cycle c_tx_sel=000, tx_dv=0. An async reset pulse mid-cycle clears the outputs without a clock edge.
- tx_ws=1 during OWNED → c_tx_ws=1 to all clients; the grant holds until busy falls.
